// File: rtl/imm_pkg.sv
// imm_pkg: opcodes, format tags and result bundle for the immediate generator.
// Shared by imm_decode and imm_gen_pipe; XLEN_MAX sizes the stored immediate.
package imm_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_Z
  } imm_fmt_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0] imm;
    imm_fmt_e            fmt;
    logic                illegal;
  } imm_res_t;

endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational inst[31:0] -> imm_res_t (imm, fmt, illegal).
// XLEN=32 zeroes imm[63:32] and rejects OP-IMM-32; IMM_GEN_CSR_EN adds FMT_Z.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0] inst,
  output imm_res_t    res
);

  localparam logic [63:0] MASK =
    (XLEN == 32) ? 64'h0000_0000_ffff_ffff : '1;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        s;
  logic        is_i;
  logic        is_s;
  logic        is_b;
  logic        is_u;
  logic        is_j;
  logic [63:0] imm_i;
  logic [63:0] imm_s;
  logic [63:0] imm_b;
  logic [63:0] imm_u;
  logic [63:0] imm_j;
  logic [63:0] imm_full;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign s   = inst[31];

  assign imm_i = {{52{s}}, inst[31:20]};
  assign imm_s = {{52{s}}, inst[31:25], inst[11:7]};
  assign imm_b = {{51{s}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {{32{s}}, inst[31:12], 12'b0};
  assign imm_j = {{43{s}}, inst[31], inst[19:12],
                  inst[20], inst[30:21], 1'b0};

  assign is_i = (opc == OPC_OPIMM)
             || (opc == OPC_LOAD)
             || ((opc == OPC_OPIMM32) && (XLEN == 64))
             || ((opc == OPC_JALR) && (f3 == 3'b000));
  assign is_s = (opc == OPC_STORE);
  assign is_b = (opc == OPC_BRANCH);
  assign is_u = (opc == OPC_LUI) || (opc == OPC_AUIPC);
  assign is_j = (opc == OPC_JAL);

`ifdef IMM_GEN_CSR_EN
  logic        is_z;
  logic [63:0] imm_z;
  // Immediate CSR ops only: csrrwi/csrrsi/csrrci.
  assign is_z  = (opc == OPC_SYSTEM) && f3[2]
              && (f3[1:0] != 2'b00);
  assign imm_z = {59'b0, inst[19:15]};
`endif

  always_comb begin
    res      = '{imm: '0, fmt: FMT_NONE, illegal: 1'b1};
    imm_full = '0;
    unique case (1'b1)
      is_i: begin
        imm_full = imm_i;
        res.fmt  = FMT_I;
      end
      is_s: begin
        imm_full = imm_s;
        res.fmt  = FMT_S;
      end
      is_b: begin
        imm_full = imm_b;
        res.fmt  = FMT_B;
      end
      is_u: begin
        imm_full = imm_u;
        res.fmt  = FMT_U;
      end
      is_j: begin
        imm_full = imm_j;
        res.fmt  = FMT_J;
      end
`ifdef IMM_GEN_CSR_EN
      is_z: begin
        imm_full = imm_z;
        res.fmt  = FMT_Z;
      end
`endif
      default: begin
        imm_full = '0;
        res.fmt  = FMT_NONE;
      end
    endcase
    res.illegal = (res.fmt == FMT_NONE);
    res.imm     = imm_full & MASK;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator behind a 2-entry skid buffer.
// Ports: clk, reset, in_valid/in_ready/in_inst, out_valid/out_ready/out_imm/out_fmt/out_illegal.
// Optional build macro IMM_GEN_CSR_EN enables the FMT_Z (zimm) decode.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int FMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [FMT_W-1:0] out_fmt,
  output logic             out_illegal
);

  localparam imm_res_t RES_RST =
    '{imm: '0, fmt: FMT_NONE, illegal: 1'b0};

  imm_res_t dec;
  imm_res_t main_q;
  imm_res_t skid_q;
  logic     main_v;
  logic     skid_v;
  logic     acc;
  logic     xfer;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .inst (in_inst),
    .res  (dec)
  );

  // in_ready depends only on state, never on out_ready.
  assign in_ready = !skid_v;
  assign acc      = in_valid && in_ready;
  assign xfer     = main_v && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= RES_RST;
      skid_q <= RES_RST;
    end else if (xfer) begin
      if (skid_v) begin
        main_q <= skid_q;
        skid_v <= 1'b0;
      end else if (acc) begin
        main_q <= dec;
      end else begin
        main_v <= 1'b0;
      end
    end else if (acc) begin
      if (!main_v) begin
        main_q <= dec;
        main_v <= 1'b1;
      end else begin
        skid_q <= dec;
        skid_v <= 1'b1;
      end
    end
  end

  assign out_valid   = main_v;
  assign out_imm     = main_q.imm[XLEN-1:0];
  assign out_fmt     = FMT_W'(main_q.fmt);
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed self-checking bench for imm_gen_pipe.
// Runs an XLEN=64 and an XLEN=32 instance side by side on shared inputs.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_inst;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;

  logic        in_ready32;
  logic        out_valid32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;
  logic        out_illegal32;

  int n_chk;
  int n_fail;

  imm_gen_pipe #(.XLEN(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_fmt     (out_fmt),
    .out_illegal (out_illegal)
  );

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready32),
    .in_inst     (in_inst),
    .out_valid   (out_valid32),
    .out_ready   (out_ready),
    .out_imm     (out_imm32),
    .out_fmt     (out_fmt32),
    .out_illegal (out_illegal32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_inst = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid: got %b want 0", out_valid);
    end
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready: got %b want 1", in_ready);
    end
    n_chk++;
    if (out_imm !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_imm: got %h want 0", out_imm);
    end
    n_chk++;
    if (out_fmt !== 3'(FMT_NONE) || out_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_fmt: got %0d/%b want 0/0",
               out_fmt, out_illegal);
    end
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_inst = 32'hFFF00093;
    tick();
    in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL addi_valid: got %b want 1", out_valid);
    end
    n_chk++;
    if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++;
      $display("FAIL addi_imm: got %h want ffffffffffffffff", out_imm);
    end
    n_chk++;
    if (out_fmt !== 3'(FMT_I) || out_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL addi_fmt: got %0d/%b want 1/0",
               out_fmt, out_illegal);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL addi_drain: got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] insts [3];
    logic [63:0] imms  [3];
    logic [2:0]  fmts  [3];
    insts = '{32'hFE20AE23, 32'hFE000CE3, 32'h0010006F};
    imms  = '{64'hFFFF_FFFF_FFFF_FFFC,
              64'hFFFF_FFFF_FFFF_FFF8,
              64'h0000_0000_0000_0800};
    fmts  = '{3'(FMT_S), 3'(FMT_B), 3'(FMT_J)};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_inst = insts[i];
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1
          || out_imm !== imms[i] || out_fmt !== fmts[i]
          || out_illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_%0d: got v=%b r=%b %h/%0d/%b want 1 1 %h/%0d/0",
                 i, out_valid, in_ready, out_imm, out_fmt,
                 out_illegal, imms[i], fmts[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_lui();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_inst = 32'h800000B7;
    tick();
    in_valid = 1'b0;
    n_chk++;
    if (out_imm !== 64'hFFFF_FFFF_8000_0000 || out_fmt !== 3'(FMT_U)) begin
      n_fail++;
      $display("FAIL lui64: got %h/%0d want ffffffff80000000/4",
               out_imm, out_fmt);
    end
    n_chk++;
    if (out_imm32 !== 32'h8000_0000 || out_fmt32 !== 3'(FMT_U)
        || out_valid32 !== 1'b1) begin
      n_fail++;
      $display("FAIL lui32: got %h/%0d/%b want 80000000/4/1",
               out_imm32, out_fmt32, out_valid32);
    end
    tick();
  endtask

  task automatic test_opimm32();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_inst = 32'h0010009B;
    tick();
    in_valid = 1'b0;
    n_chk++;
    if (out_imm !== 64'h1 || out_fmt !== 3'(FMT_I)
        || out_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL addiw64: got %h/%0d/%b want 1/1/0",
               out_imm, out_fmt, out_illegal);
    end
    n_chk++;
    if (out_imm32 !== 32'h0 || out_fmt32 !== 3'(FMT_NONE)
        || out_illegal32 !== 1'b1) begin
      n_fail++;
      $display("FAIL addiw32: got %h/%0d/%b want 0/0/1",
               out_imm32, out_fmt32, out_illegal32);
    end
    tick();
  endtask

  task automatic test_illegal();
    logic [31:0] insts [2];
    insts = '{32'h00001067, 32'h00000033};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_inst = insts[i];
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || out_imm !== 64'h0
          || out_fmt !== 3'(FMT_NONE) || out_illegal !== 1'b1) begin
        n_fail++;
        $display("FAIL illegal_%0d: got v=%b %h/%0d/%b want 1 0/0/1",
                 i, out_valid, out_imm, out_fmt, out_illegal);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_inst = 32'h00500093;
    tick();
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_imm !== 64'd5) begin
      n_fail++;
      $display("FAIL bp_first: got r=%b v=%b imm=%h want 1 1 5",
               in_ready, out_valid, out_imm);
    end
    in_inst = 32'h00A00093;
    tick();
    n_chk++;
    if (in_ready !== 1'b0 || out_imm !== 64'd5) begin
      n_fail++;
      $display("FAIL bp_full: got r=%b imm=%h want 0 5",
               in_ready, out_imm);
    end
    in_inst = 32'h00F00093;
    tick();
    n_chk++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_imm !== 64'd5) begin
      n_fail++;
      $display("FAIL bp_hold: got r=%b v=%b imm=%h want 0 1 5",
               in_ready, out_valid, out_imm);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_imm !== 64'd10) begin
      n_fail++;
      $display("FAIL bp_second: got r=%b v=%b imm=%h want 1 1 a",
               in_ready, out_valid, out_imm);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_empty: got v=%b r=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_inst = 32'hFE20AE23;
    tick();
    in_inst = 32'h800000B7;
    tick();
    in_valid = 1'b0;
    n_chk++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_setup: got r=%b v=%b want 0 1",
               in_ready, out_valid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== 64'h0
        || out_fmt !== 3'(FMT_NONE) || out_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_state: got v=%b r=%b %h/%0d/%b want 0 1 0/0/0",
               out_valid, in_ready, out_imm, out_fmt, out_illegal);
    end
    out_ready = 1'b1;
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_flushed: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_csr();
    logic [63:0] exp_imm;
    logic [2:0]  exp_fmt;
    logic        exp_ill;
`ifdef IMM_GEN_CSR_EN
    exp_imm = 64'hF;
    exp_fmt = 3'(FMT_Z);
    exp_ill = 1'b0;
`else
    exp_imm = 64'h0;
    exp_fmt = 3'(FMT_NONE);
    exp_ill = 1'b1;
`endif
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_inst = 32'h0007D073;
    tick();
    in_valid = 1'b0;
    n_chk++;
    if (out_imm !== exp_imm || out_fmt !== exp_fmt
        || out_illegal !== exp_ill) begin
      n_fail++;
      $display("FAIL csrrwi: got %h/%0d/%b want %h/%0d/%b",
               out_imm, out_fmt, out_illegal,
               exp_imm, exp_fmt, exp_ill);
    end
    tick();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_lui();
    test_opimm32();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_csr();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the RV decode stage; successor to the combinational sign-extend unit.
- Decodes the immediate of every RV base format from a 32-bit instruction.
- Sign-extends it to XLEN, tags the format, and flags instructions that carry no immediate.
- Result is registered behind a valid/ready handshake with a 2-entry skid buffer, so decode back-pressure never drops or reorders instructions.

Parameters:
XLEN, 64, output immediate width; legal values 32 or 64.
FMT_W, 3, width of the format tag; fixed by imm_pkg.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  instruction valid.
in_ready  out  1  block can accept an instruction this cycle.
in_inst  in  32  raw instruction word.
out_valid  out  1  registered result valid.
out_ready  in  1  consumer accepts the result this cycle.
out_imm  out  XLEN  sign/zero-extended immediate.
out_fmt  out  FMT_W  imm_fmt_e tag of the decoded format.
out_illegal  out  1  opcode or funct3 carries no immediate.

Behaviour:
- Reset (synchronous, sampled on clk when reset=1):
  - out_valid=0, out_imm=0, out_fmt=FMT_NONE, out_illegal=0, skid empty.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards both held entries.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Latency: 1 cycle from accept to out_valid when the pipe is empty.
- Storage: main register drives out_*; one skid register behind it.
  - in_ready = !skid_valid (registered; no combinational path from out_ready).
  - Accept while main is empty, or main transfers the same cycle: load main.
  - Accept while main holds an entry and does not transfer: load skid.
  - Main transfers while skid is full: skid moves to main, skid empties, in_ready rises next cycle.
  - Order is strictly FIFO; out_* is stable while out_valid & !out_ready.
- Decode (combinational, all bit positions per RV spec; sign bit is always inst[31]):
  - I (FMT_I): opcodes 0010011, 0000011, 0011011, and 1100111 with funct3=000. imm = sext(inst[31:20]). Shift immediates are passed raw; the ALU masks shamt.
  - S (FMT_S): opcode 0100011. imm = sext({inst[31:25], inst[11:7]}).
  - B (FMT_B): opcode 1100011. imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U (FMT_U): opcodes 0110111, 0010111. imm = sext({inst[31:12], 12'b0}).
  - J (FMT_J): opcode 1101111. imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - Any other opcode, or 1100111 with funct3≠000: FMT_NONE, imm=0, illegal=1.
- Width: sext replicates the format sign bit up to XLEN-1.
  - XLEN=32: U imm is exactly {inst[31:12], 12'b0}.
  - XLEN=32: opcode 0011011 is illegal.
- Simultaneous accept + transfer with skid empty: main reloads; out_valid stays 1.

Optional Feature:
IMM_GEN_CSR_EN
- Defined: opcode 1110011 with funct3 ∈ {101, 110, 111} decodes as FMT_Z, imm = zext(inst[19:15]).
- Not defined: all 1110011 encodings give FMT_NONE, illegal=1; FMT_Z never appears.
- The enum value exists in both builds.

Decomposition:
- imm_pkg holds:
  - opcode localparams OPC_OPIMM, OPC_LOAD, OPC_OPIMM32, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM;
  - typedef enum logic [2:0] imm_fmt_e {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_Z};
  - packed struct imm_res_t {imm, fmt, illegal}.
- Sub-module imm_decode: purely combinational, parametrised by XLEN, inst → imm_res_t.
- imm_gen_pipe instantiates imm_decode and holds the main + skid registers of imm_res_t.

Test Plan:
- XLEN=64, out_ready=1, send 0xFFF00093 (addi x1,x0,-1) → one cycle later out_valid=1, out_imm=0xFFFFFFFFFFFFFFFF, FMT_I, illegal=0.
- Send 0xFE20AE23 (sw -4), 0xFE000CE3 (beq -8), 0x0010006F (jal +2048) back-to-back → 0xFFFFFFFFFFFFFFFC/FMT_S, 0xFFFFFFFFFFFFFFF8/FMT_B, 0x0000000000000800/FMT_J, in order, one per cycle.
- Send 0x800000B7 (lui) → 0xFFFFFFFF80000000 at XLEN=64, 0x80000000 at XLEN=32; FMT_U.
- Send 0x00001067 (opcode 1100111, funct3=001) and 0x00000033 (R-type) → FMT_NONE, imm=0, illegal=1 for both.
- Back-pressure: out_ready=0, offer 3 instructions → 2 accepted, in_ready=0 from the cycle after the 2nd accept; raise out_ready → both emerge in order, in_ready=1 again.
- Reset mid-operation: assert reset with both entries held → next cycle out_valid=0, in_ready=1, all outputs at reset values.
- Build with IMM_GEN_CSR_EN: send 0x0007D073 (csrrwi, zimm=15) → imm=0xF, FMT_Z. Without the macro, the same word gives illegal=1.
